palette_arbiter: RTL and testbench
==================================

PALETTE_ARBITER -- requirements
Module: palette_arbiter

Interface
REQ-001 Parameter IDX_W, default 4, palette index width.
REQ-002 Parameter DATA_W, default 8, palette colour byte width.
REQ-003 Parameter BURST_MAX, default 4, maximum consecutive grants to one requester while the other waits; legal range 1..15.
REQ-004 Port clk  input  1  system clock; single clock domain.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port tile_req  input  1  tile renderer lookup request.
REQ-007 Port tile_idx  input  IDX_W  tile renderer palette index.
REQ-008 Port tile_gnt  output  1  tile request accepted this cycle.
REQ-009 Port spr_req  input  1  sprite renderer lookup request.
REQ-010 Port spr_idx  input  IDX_W  sprite renderer palette index.
REQ-011 Port spr_gnt  output  1  sprite request accepted this cycle.
REQ-012 Port pal_idx  output  IDX_W  index driven to the colour store.
REQ-013 Port pal_byte  input  DATA_W  colour byte returned combinationally by the colour store.
REQ-014 Port rsp_valid  output  1  response strobe.
REQ-015 Port rsp_id  output  1  response owner: 0 = tile, 1 = sprite.
REQ-016 Port rsp_byte  output  DATA_W  registered colour byte.
REQ-017 Port rsp_transp  output  1  high when the response is a sprite lookup of index 0.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, SERVE_TILE and SERVE_SPR.
REQ-019 A lookup SHALL be accepted in a cycle when req and gnt are both high; at most one gnt SHALL be high per cycle.
REQ-020 gnt SHALL be combinational from the current state, burst_cnt and both req inputs; pal_idx SHALL equal the granted requester's idx, and pal_idx SHALL hold its previous value when nothing is granted.
REQ-021 IDLE: with only one requester active, the FSM SHALL grant it and go to its SERVE state; with both active, it SHALL grant sprite (fixed priority); with neither active, it SHALL remain in IDLE.
REQ-022 SERVE_X with X requesting and the other idle: the FSM SHALL grant X, stay in SERVE_X, and hold burst_cnt at 1.
REQ-023 SERVE_X with both requesting and burst_cnt < BURST_MAX: the FSM SHALL grant X and increment burst_cnt.
REQ-024 SERVE_X with both requesting and burst_cnt == BURST_MAX: the FSM SHALL grant the other requester, move to the other SERVE state, and set burst_cnt to 1.
REQ-025 SERVE_X with X idle: the FSM SHALL apply the IDLE decision in the same cycle (no bubble cycle), or return to IDLE if neither requests.
REQ-026 burst_cnt SHALL be a ceil(log2(BURST_MAX+1))-bit unsigned counter that saturates at BURST_MAX and never wraps.
REQ-027 Response latency SHALL be exactly 1 cycle: in the cycle after an accept, rsp_valid = 1, rsp_byte = pal_byte sampled at the accept, and rsp_id = the accepted requester.
REQ-028 rsp_transp SHALL be 1 only when rsp_id = 1 and the accepted index was 0.
REQ-029 rsp_byte, rsp_id and rsp_transp SHALL hold their values when rsp_valid = 0.
REQ-030 Back-to-back accepts SHALL produce back-to-back responses at full throughput of one lookup per cycle.

Reset
REQ-031 On rst the block SHALL set state = IDLE, burst_cnt = 0, rsp_valid = 0, rsp_byte = 0, rsp_id = 0, rsp_transp = 0 and pal_idx = 0.
REQ-032 While rst is high, tile_gnt and spr_gnt SHALL be 0.
REQ-033 A lookup accepted in the cycle rst asserts SHALL produce no response.

Configuration
REQ-034 Macro PAL_ARB_RR_EN defined: the IDLE tie-break SHALL grant the requester not served by the most recent accept (tracked by a 1-bit last_id register, reset to 0, which makes sprite win the first tie).
REQ-035 Macro PAL_ARB_RR_EN undefined: the IDLE tie-break SHALL always grant sprite, and no last_id register SHALL exist.

Structure
REQ-036 Shared package pal_pkg SHALL hold the state enum pal_arb_state_t and the constants PAL_IDX_W = 4, PAL_DATA_W = 8 and RSP_ID_TILE/RSP_ID_SPR.
REQ-037 The block SHALL be a single module with no sub-modules; the colour store SHALL be instantiated beside it by the parent.

Verification
REQ-038 Tile requests only with idx 3, 3, 5 -> tile_gnt high 3 cycles; rsp_byte 0xef, 0xef, 0xf8 with rsp_id 0, each 1 cycle after its accept.
REQ-039 Both requesting from IDLE with BURST_MAX = 4 -> sprite granted 4 cycles, then tile 4 cycles, alternating; no cycle without a grant.
REQ-040 Sprite request with idx 0 -> rsp_transp = 1 and rsp_byte 0x00; tile request with idx 0 -> rsp_transp = 0.
REQ-041 rst pulsed while in SERVE_TILE mid-burst -> the next cycle shows rsp_valid = 0 and state = IDLE, and the first grant after reset follows the IDLE rules.
REQ-042 With PAL_ARB_RR_EN defined: single tile accept, then both requesting in IDLE -> spr_gnt wins the tie; repeat after a sprite accept -> tile_gnt wins the tie.

Source files
------------

// File: rtl/pal_pkg.sv
// Shared definitions for the palette lookup arbiter: default widths,
// response owner encoding and the arbiter state enumeration.
package pal_pkg;

  localparam int PAL_IDX_W  = 4;
  localparam int PAL_DATA_W = 8;

  // Value carried on rsp_id to say who owns a response.
  localparam logic RSP_ID_TILE = 1'b0;
  localparam logic RSP_ID_SPR  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SERVE_TILE = 2'd1,
    ST_SERVE_SPR  = 2'd2
  } pal_arb_state_t;

endpackage

// File: rtl/palette_arbiter.sv
// palette_arbiter: shares one combinational colour store between the tile
// renderer and the sprite renderer. One lookup is accepted per cycle; the
// colour byte comes back registered one cycle later.
//
// Handshake: a lookup is accepted in a cycle when req and gnt are both high.
// gnt is combinational from state, burst count and both req inputs; a
// requester holds req (and idx) until it sees gnt. The response strobe
// rsp_valid is high for exactly one cycle, one cycle after the accept, and
// has no back-pressure.
//
// Optional feature: define PAL_ARB_RR_EN to make the IDLE tie-break go to
// the requester not served by the most recent accept; otherwise the sprite
// renderer always wins a tie.
module palette_arbiter
  import pal_pkg::*;
#(
  parameter int IDX_W     = PAL_IDX_W,
  parameter int DATA_W    = PAL_DATA_W,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tile_req,
  input  logic [IDX_W-1:0]  tile_idx,
  output logic              tile_gnt,
  input  logic              spr_req,
  input  logic [IDX_W-1:0]  spr_idx,
  output logic              spr_gnt,
  output logic [IDX_W-1:0]  pal_idx,
  input  logic [DATA_W-1:0] pal_byte,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_byte,
  output logic              rsp_transp,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] S_IDLE       = ST_IDLE;
  localparam logic [1:0] S_SERVE_TILE = ST_SERVE_TILE;
  localparam logic [1:0] S_SERVE_SPR  = ST_SERVE_SPR;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_pal_idx;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_byte;
  logic              r_rsp_transp;

  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_tile_gnt;
  logic              w_spr_gnt;
  logic              w_use_idle;
  logic              w_tie_spr;
  logic              w_idle_spr;
  logic              w_idle_tile;
  logic              w_accept;

`ifdef PAL_ARB_RR_EN
  logic r_last_id;

  // Remember who was served last so a tie goes to the other requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_id <= RSP_ID_TILE;
    end else if (w_accept) begin
      r_last_id <= w_spr_gnt ? RSP_ID_SPR : RSP_ID_TILE;
    end
  end

  assign w_tie_spr = (r_last_id == RSP_ID_TILE);
`else
  assign w_tie_spr = 1'b1;
`endif

  // Decision taken from IDLE, or from a SERVE state whose owner went idle.
  assign w_idle_spr  = spr_req & (~tile_req | w_tie_spr);
  assign w_idle_tile = tile_req & ~w_idle_spr;

  // Grant selection and next state / burst count.
  always_comb begin
    w_tile_gnt  = 1'b0;
    w_spr_gnt   = 1'b0;
    w_use_idle  = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_SERVE_TILE: begin
        if (tile_req && spr_req) begin
          if (r_cnt >= CNT_MAX) begin
            w_spr_gnt   = 1'b1;
            w_state_nxt = S_SERVE_SPR;
            w_cnt_nxt   = CNT_ONE;
          end else begin
            w_tile_gnt = 1'b1;
            w_cnt_nxt  = r_cnt + CNT_ONE;
          end
        end else if (tile_req) begin
          w_tile_gnt = 1'b1;
          w_cnt_nxt  = CNT_ONE;
        end else begin
          w_use_idle = 1'b1;
        end
      end
      S_SERVE_SPR: begin
        if (tile_req && spr_req) begin
          if (r_cnt >= CNT_MAX) begin
            w_tile_gnt  = 1'b1;
            w_state_nxt = S_SERVE_TILE;
            w_cnt_nxt   = CNT_ONE;
          end else begin
            w_spr_gnt = 1'b1;
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end else if (spr_req) begin
          w_spr_gnt = 1'b1;
          w_cnt_nxt = CNT_ONE;
        end else begin
          w_use_idle = 1'b1;
        end
      end
      default: w_use_idle = 1'b1;
    endcase

    if (w_use_idle) begin
      if (w_idle_spr) begin
        w_spr_gnt   = 1'b1;
        w_state_nxt = S_SERVE_SPR;
        w_cnt_nxt   = CNT_ONE;
      end else if (w_idle_tile) begin
        w_tile_gnt  = 1'b1;
        w_state_nxt = S_SERVE_TILE;
        w_cnt_nxt   = CNT_ONE;
      end else begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    end

    // No lookup may be accepted while reset is held.
    if (rst) begin
      w_tile_gnt = 1'b0;
      w_spr_gnt  = 1'b0;
    end
  end

  assign w_accept = w_tile_gnt | w_spr_gnt;

  // The colour store sees the granted index, or the last one when idle.
  assign pal_idx = w_spr_gnt  ? spr_idx  :
                   w_tile_gnt ? tile_idx : r_pal_idx;

  // State, burst count and the registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_pal_idx    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= RSP_ID_TILE;
      r_rsp_byte   <= '0;
      r_rsp_transp <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pal_idx   <= pal_idx;
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_rsp_id     <= w_spr_gnt ? RSP_ID_SPR : RSP_ID_TILE;
        r_rsp_byte   <= pal_byte;
        r_rsp_transp <= w_spr_gnt & (spr_idx == '0);
      end
    end
  end

  assign tile_gnt   = w_tile_gnt;
  assign spr_gnt    = w_spr_gnt;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_byte   = r_rsp_byte;
  assign rsp_transp = r_rsp_transp;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_palette_arbiter.sv
// Bench for palette_arbiter: colour store model, fixed vector table,
// hand-written corner sequences and randomized traffic against a
// behavioural reference model.
module tb_palette_arbiter;
  import pal_pkg::*;

  localparam int BMAX = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tile_req = 1'b0;
  logic [3:0] tile_idx = 4'd0;
  logic       tile_gnt;
  logic       spr_req = 1'b0;
  logic [3:0] spr_idx = 4'd0;
  logic       spr_gnt;
  logic [3:0] pal_idx;
  logic [7:0] pal_byte;
  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_byte;
  logic       rsp_transp;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  palette_arbiter #(.IDX_W(4), .DATA_W(8), .BURST_MAX(BMAX)) dut (
    .clk(clk), .rst(rst),
    .tile_req(tile_req), .tile_idx(tile_idx), .tile_gnt(tile_gnt),
    .spr_req(spr_req), .spr_idx(spr_idx), .spr_gnt(spr_gnt),
    .pal_idx(pal_idx), .pal_byte(pal_byte),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_byte(rsp_byte),
    .rsp_transp(rsp_transp), .dbg_state(dbg_state)
  );

  // Colour store beside the arbiter (combinational).
  function automatic logic [7:0] lut_f(input logic [3:0] i);
    case (i)
      4'd0: lut_f = 8'h00;  4'd1: lut_f = 8'h11;  4'd2: lut_f = 8'h22;
      4'd3: lut_f = 8'hef;  4'd4: lut_f = 8'h44;  4'd5: lut_f = 8'hf8;
      4'd6: lut_f = 8'h66;  4'd7: lut_f = 8'h7a;  4'd8: lut_f = 8'h88;
      4'd9: lut_f = 8'h99;  4'd10: lut_f = 8'haa; 4'd11: lut_f = 8'hbb;
      4'd12: lut_f = 8'hcc; 4'd13: lut_f = 8'hdd; 4'd14: lut_f = 8'hee;
      default: lut_f = 8'hff;
    endcase
  endfunction

  assign pal_byte = lut_f(pal_idx);

  // ---------------- scoreboard bookkeeping ----------------
  int   n_checks = 0;
  int   n_fail   = 0;
  logic obs_tg, obs_sg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 nobody, 0 tile, 1 sprite. run: consecutive grants to owner
  // while contested (an uncontested grant restarts the run at 1).
  int         m_owner, m_run, m_last;
  logic [3:0] m_pidx;
  logic       m_rid, m_rtr;
  logic [7:0] m_rbyte;
  logic [7:0] exp_q[$];

  task automatic model_reset();
    m_owner = -1; m_run = 0; m_last = 0;
    m_pidx = 4'd0; m_rid = 1'b0; m_rtr = 1'b0; m_rbyte = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_step(input logic r, input logic t, input logic [3:0] ti,
                            input logic s, input logic [3:0] si,
                            output logic e_tg, output logic e_sg, output logic [3:0] e_pidx,
                            output logic e_rv, output logic e_rid, output logic [7:0] e_rb,
                            output logic e_rtr);
    int win;
    win = -1;
    e_pidx = m_pidx;
    if (r) begin
      model_reset();
    end else begin
      if (t && s) begin
        if (m_owner < 0) begin
`ifdef PAL_ARB_RR_EN
          win = (m_last == 0) ? 1 : 0;
`else
          win = 1;
`endif
          m_run = 1;
        end else if (m_run < BMAX) begin
          win = m_owner;
          m_run = m_run + 1;
        end else begin
          win = 1 - m_owner;
          m_run = 1;
        end
      end else if (t) begin
        win = 0; m_run = 1;
      end else if (s) begin
        win = 1; m_run = 1;
      end else begin
        m_run = 0;
      end
      m_owner = win;
      if (win >= 0) begin
        m_last  = win;
        e_pidx  = (win == 1) ? si : ti;
        m_pidx  = e_pidx;
        m_rid   = (win == 1);
        m_rbyte = lut_f(e_pidx);
        m_rtr   = (win == 1) && (si == 4'd0);
        exp_q.push_back(m_rbyte);
      end
    end
    e_tg  = (win == 0);
    e_sg  = (win == 1);
    e_rv  = (win >= 0);
    e_rid = m_rid;
    e_rb  = m_rbyte;
    e_rtr = m_rtr;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic r, input logic t, input logic [3:0] ti,
                             input logic s, input logic [3:0] si,
                             input logic e_tg, input logic e_sg, input logic [3:0] e_pidx,
                             input logic e_rv, input logic e_rid, input logic [7:0] e_rb,
                             input logic e_rtr);
    @(negedge clk);
    rst = r; tile_req = t; tile_idx = ti; spr_req = s; spr_idx = si;
    #1;
    check("tile_gnt", tile_gnt, e_tg);
    check("spr_gnt", spr_gnt, e_sg);
    check("pal_idx", pal_idx, e_pidx);
    obs_tg = tile_gnt;
    obs_sg = spr_gnt;
    @(posedge clk);
    #1;
    check("rsp_valid", rsp_valid, e_rv);
    check("rsp_id", rsp_id, e_rid);
    check("rsp_byte", rsp_byte, e_rb);
    check("rsp_transp", rsp_transp, e_rtr);
    if (rsp_valid && exp_q.size() > 0) begin
      check("rsp_order", rsp_byte, exp_q.pop_front());
    end
  endtask

  task automatic model_cycle(input logic r, input logic t, input logic [3:0] ti,
                             input logic s, input logic [3:0] si);
    logic e_tg, e_sg, e_rv, e_rid, e_rtr;
    logic [3:0] e_pidx;
    logic [7:0] e_rb;
    model_step(r, t, ti, s, si, e_tg, e_sg, e_pidx, e_rv, e_rid, e_rb, e_rtr);
    drive_cycle(r, t, ti, s, si, e_tg, e_sg, e_pidx, e_rv, e_rid, e_rb, e_rtr);
  endtask

  // Reset with both requests high: no grant may appear while rst is high.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tile_req = 1'b1; spr_req = 1'b1; tile_idx = 4'd3; spr_idx = 4'd6;
    #1;
    check("rst_tile_gnt", tile_gnt, 1'b0);
    check("rst_spr_gnt", spr_gnt, 1'b0);
    @(negedge clk);
    rst = 1'b0; tile_req = 1'b0; spr_req = 1'b0;
    #1;
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_id", rsp_id, 1'b0);
    check("reset_rsp_byte", rsp_byte, 8'h00);
    check("reset_rsp_transp", rsp_transp, 1'b0);
    check("reset_pal_idx", pal_idx, 4'd0);
    check("reset_state", dbg_state, ST_IDLE);
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic t; logic [3:0] ti; logic s; logic [3:0] si;
    logic tg; logic sg; logic [3:0] pidx;
    logic rv; logic rid; logic [7:0] rb; logic rtr;
  } vec_t;

  function automatic vec_t mk(input logic t, input logic [3:0] ti, input logic s,
                              input logic [3:0] si, input logic tg, input logic sg,
                              input logic [3:0] pidx, input logic rv, input logic rid,
                              input logic [7:0] rb, input logic rtr);
    vec_t v;
    v.t = t; v.ti = ti; v.s = s; v.si = si; v.tg = tg; v.sg = sg; v.pidx = pidx;
    v.rv = rv; v.rid = rid; v.rb = rb; v.rtr = rtr;
    return v;
  endfunction

  vec_t vecs[9];

  initial begin
    logic r, t, s;
    logic [3:0] ti, si;

    vecs[0] = mk(1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 8'hef, 1'b0);
    vecs[1] = mk(1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 8'hef, 1'b0);
    vecs[2] = mk(1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 8'hf8, 1'b0);
    vecs[3] = mk(1'b0, 4'd9, 1'b0, 4'd9, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 8'hf8, 1'b0);
    vecs[4] = mk(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 8'h00, 1'b1);
    vecs[5] = mk(1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 8'h00, 1'b0);
    vecs[6] = mk(1'b0, 4'd1, 1'b0, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    vecs[7] = mk(1'b1, 4'd2, 1'b1, 4'd7, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 8'h7a, 1'b0);
    vecs[8] = mk(1'b0, 4'd2, 1'b0, 4'd7, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 8'h7a, 1'b0);

    // Power-up: hold reset a few cycles before any checking.
    repeat (3) @(negedge clk);
    do_reset();

    // Table: tile stream 3,3,5, idle hold, transparent sprite, tile idx 0, tie.
    for (int i = 0; i < 9; i++) begin
      drive_cycle(1'b0, vecs[i].t, vecs[i].ti, vecs[i].s, vecs[i].si,
                  vecs[i].tg, vecs[i].sg, vecs[i].pidx,
                  vecs[i].rv, vecs[i].rid, vecs[i].rb, vecs[i].rtr);
    end

    // Both requesting from IDLE: sprite 4, tile 4, alternating, never idle.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      model_cycle(1'b0, 1'b1, 4'd2, 1'b1, 4'd9);
      check("burst_owner_spr", obs_sg, ((k / BMAX) % 2) == 0);
      check("burst_no_gap", obs_tg | obs_sg, 1'b1);
    end

    // Reset mid tile burst, then IDLE rules on the first grant.
    do_reset();
    model_cycle(1'b0, 1'b1, 4'd1, 1'b0, 4'd0);
    model_cycle(1'b0, 1'b1, 4'd1, 1'b1, 4'd8);
    model_cycle(1'b0, 1'b1, 4'd1, 1'b1, 4'd8);
    check("mid_burst_state", dbg_state, ST_SERVE_TILE);
    model_cycle(1'b1, 1'b1, 4'd1, 1'b1, 4'd8);
    check("post_rst_state", dbg_state, ST_IDLE);
    model_cycle(1'b0, 1'b1, 4'd1, 1'b1, 4'd8);
    check("post_rst_first_spr", obs_sg, 1'b1);

    // Tie-break after a tile accept and after a sprite accept.
    do_reset();
    model_cycle(1'b0, 1'b1, 4'd4, 1'b0, 4'd0);
    model_cycle(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    model_cycle(1'b0, 1'b1, 4'd4, 1'b1, 4'd6);
    check("tie_after_tile_spr", obs_sg, 1'b1);
    model_cycle(1'b0, 1'b0, 4'd0, 1'b1, 4'd6);
    model_cycle(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    model_cycle(1'b0, 1'b1, 4'd4, 1'b1, 4'd6);
`ifdef PAL_ARB_RR_EN
    check("tie_after_spr_tile", obs_tg, 1'b1);
`else
    check("tie_after_spr_spr", obs_sg, 1'b1);
`endif

    // Randomized traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 59) == 0);
      t  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 2) != 0);
      ti = 4'($urandom_range(0, 15));
      si = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      model_cycle(r, t, ti, s, si);
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
